// File: rtl/button_event_decoder.sv
// Turns the debounced button level into press/release edges and click/double/long events.
// Every pulse is registered (one cycle after its sample). There is no backpressure; pulses are never held.
module button_event_decoder #(
  parameter int LONG_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 25_000_000,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 debounced,
  output logic                 press_pulse,
  output logic                 release_pulse,
  output logic                 single_click,
  output logic                 double_click,
  output logic                 long_press,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic                 busy
);

  localparam int HW = $clog2(LONG_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    PRESSED2
  } state_t;

  state_t          state, state_nxt;
  logic            btn_q;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic            single_nxt, double_nxt, long_nxt;
  logic            rise, fall;

  assign rise = debounced & ~btn_q;
  assign fall = ~debounced & btn_q;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    gap_nxt    = gap_cnt;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (debounced) begin
          state_nxt = PRESSED;
          hold_nxt  = '0;
        end
      end
      PRESSED: begin
        // Release wins over the long-hold compare on the same edge.
        if (!debounced) begin
          state_nxt = WAIT_GAP;
          gap_nxt   = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = LONG_HELD;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      LONG_HELD: begin
        if (!debounced) state_nxt = IDLE;
      end
      WAIT_GAP: begin
        // A press on the timeout edge still counts as the second click.
        if (debounced) begin
          double_nxt = 1'b1;
          state_nxt  = PRESSED2;
        end else if (gap_cnt == GAP_LAST) begin
          single_nxt = 1'b1;
          state_nxt  = IDLE;
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      PRESSED2: begin
        if (!debounced) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      btn_q         <= 1'b0;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      single_click  <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      event_count   <= '0;
    end else begin
      state         <= state_nxt;
      btn_q         <= debounced;
      hold_cnt      <= hold_nxt;
      gap_cnt       <= gap_nxt;
      press_pulse   <= rise;
      release_pulse <= fall;
      single_click  <= single_nxt;
      double_click  <= double_nxt;
      long_press    <= long_nxt;
      if (single_nxt | double_nxt | long_nxt)
        event_count <= event_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed scenarios for button_event_decoder with a per-cycle scoreboard and per-scenario event tallies.
module tb_button_event_decoder;

  localparam int L  = 8;
  localparam int G  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          debounced = 1'b0;
  logic          press_pulse, release_pulse, single_click, double_click, long_press, busy;
  logic [CW-1:0] event_count;

  button_event_decoder #(.LONG_CYCLES(L), .GAP_CYCLES(G), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .debounced(debounced),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .single_click(single_click), .double_click(double_click),
    .long_press(long_press), .event_count(event_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          press, rel, single, dbl, lng, busy;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;
  int t_press, t_rel, t_single, t_dbl, t_long;

  // Reference: timing expressed as edge distances from the rise (E) and release (R).
  localparam int P_IDLE = 0, P_PRESS = 1, P_LONG = 2, P_WAIT = 3, P_PRESS2 = 4;
  int m_phase = P_IDLE;
  int now = 0, e_rise = 0, e_rel = 0;
  logic m_btnq = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  task automatic model_push(input logic d, input logic r);
    vec_t e;
    e = '0;
    now++;
    if (r) begin
      m_phase = P_IDLE; m_btnq = 1'b0; m_cnt = '0;
    end else begin
      e.press = d & ~m_btnq;
      e.rel   = ~d & m_btnq;
      m_btnq  = d;
      case (m_phase)
        P_IDLE:   if (d) begin m_phase = P_PRESS; e_rise = now; end
        P_PRESS:  if (!d) begin m_phase = P_WAIT; e_rel = now; end
                  else if (now - e_rise == L) begin e.lng = 1'b1; m_phase = P_LONG; end
        P_LONG:   if (!d) m_phase = P_IDLE;
        P_WAIT:   if (d) begin e.dbl = 1'b1; m_phase = P_PRESS2; end
                  else if (now - e_rel == G) begin e.single = 1'b1; m_phase = P_IDLE; end
        default:  if (!d) m_phase = P_IDLE;
      endcase
      if (e.single | e.dbl | e.lng) m_cnt = m_cnt + 1'b1;
    end
    e.cnt  = m_cnt;
    e.busy = (m_phase != P_IDLE);
    sb_q.push_back(e);
  endtask

  task automatic step(input logic d, input logic r);
    vec_t exp_v, obs;
    @(negedge clk);
    debounced = d;
    reset = r;
    model_push(d, r);
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    obs = {press_pulse, release_pulse, single_click, double_click, long_press, busy, event_count};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL cycle%0d observed=%b expected=%b (press rel single dbl long busy cnt)", now, obs, exp_v);
    end
    t_press  += int'(press_pulse);
    t_rel    += int'(release_pulse);
    t_single += int'(single_click);
    t_dbl    += int'(double_click);
    t_long   += int'(long_press);
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0);
  endtask

  task automatic clear_tally();
    t_press = 0; t_rel = 0; t_single = 0; t_dbl = 0; t_long = 0;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    clear_tally();
  endtask

  task automatic check_tally(input string tag, input int p, input int r, input int s,
                             input int d, input int l, input int c);
    int obs_t[6];
    int exp_t[6];
    obs_t = '{t_press, t_rel, t_single, t_dbl, t_long, int'(event_count)};
    exp_t = '{p, r, s, d, l, c};
    vectors++;
    assert (obs_t == exp_t) else begin
      miscompares++;
      $error("FAIL %s tally observed p%0d r%0d s%0d d%0d l%0d cnt%0d expected p%0d r%0d s%0d d%0d l%0d cnt%0d",
             tag, obs_t[0], obs_t[1], obs_t[2], obs_t[3], obs_t[4], obs_t[5],
             exp_t[0], exp_t[1], exp_t[2], exp_t[3], exp_t[4], exp_t[5]);
    end
    clear_tally();
  endtask

  initial begin
    clear_tally();
    // 1: reset with the button held, then released while idle
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    clear_tally();
    hold(1'b0, 6);
    check_tally("reset", 0, 0, 0, 0, 0, 0);

    // 2: single click
    do_reset();
    hold(1'b1, 3); hold(1'b0, 7);
    check_tally("single", 1, 1, 1, 0, 0, 1);

    // 3: double click
    do_reset();
    hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 7);
    check_tally("double", 2, 2, 0, 1, 0, 1);

    // 4: long press held well past the threshold
    do_reset();
    hold(1'b1, 29); hold(1'b0, 7);
    check_tally("long", 1, 1, 0, 0, 1, 1);

    // 5a: second press on the last edge of the window
    do_reset();
    hold(1'b1, 3); hold(1'b0, 4); hold(1'b1, 2); hold(1'b0, 7);
    check_tally("gap_edge", 2, 2, 0, 1, 0, 1);

    // 5b: second press one edge too late
    do_reset();
    hold(1'b1, 3); hold(1'b0, 5); hold(1'b1, 3); hold(1'b0, 7);
    check_tally("gap_late", 2, 2, 2, 0, 0, 2);

    // 5c: release on the long-hold compare edge is still short
    do_reset();
    hold(1'b1, 8); hold(1'b0, 7);
    check_tally("long_edge", 1, 1, 1, 0, 0, 1);

    // 6a: counter wraps after 16 events
    do_reset();
    for (int k = 0; k < 16; k++) begin
      hold(1'b1, 2); hold(1'b0, 6);
    end
    check_tally("wrap", 16, 16, 16, 0, 0, 0);

    // 6b: reset mid long press aborts it
    do_reset();
    hold(1'b1, 4);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    hold(1'b0, 14);
    check_tally("abort", 1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
